// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: doubleword RAM in the lower
// half of the address space, memory-mapped counters, GPIO and ID in the upper half.
module dmem_responder #(
    parameter int unsigned d_addr_63 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_mem_we,
    input  logic [d_addr_63-1:0] d_mem_addr,
    inout  wire  logic [63:0]    d_mem_data,
    output logic [63:0]          gpio_out
);

    localparam int unsigned WORD_W = d_addr_63 - 4;
    localparam int unsigned DEPTH  = 2 ** WORD_W;
    localparam logic [63:0] ID_VALUE = 64'h0000_0000_D0E5_0001;

    typedef enum logic [1:0] {
        REG_CYCLE = 2'd0,
        REG_STORE = 2'd1,
        REG_GPIO  = 2'd2,
        REG_ID    = 2'd3
    } mmio_reg_e;

    logic [63:0]       ram [DEPTH];
    logic [63:0]       cycle_cnt;
    logic [63:0]       store_cnt;
    logic [63:0]       gpio;
    logic [63:0]       read_data;
    logic [WORD_W-1:0] word;
    logic              is_mmio;
    mmio_reg_e         mmio_reg;
    logic              ram_wr;
    logic              mmio_wr;
    logic              unused_addr_bits;

    assign word     = d_mem_addr[d_addr_63-2:3];
    assign is_mmio  = d_mem_addr[d_addr_63-1];
    assign mmio_reg = mmio_reg_e'(word[1:0]);
    assign ram_wr   = d_mem_we && !is_mmio;
    assign mmio_wr  = d_mem_we && is_mmio;

    // Byte-offset bits are ignored; accesses are always doubleword-aligned.
    assign unused_addr_bits = ^d_mem_addr[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram <= '{default: '0};
        end else if (ram_wr) begin
            ram[word] <= d_mem_data;
        end
    end

    // A software load of the cycle counter takes priority over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (mmio_wr && mmio_reg == REG_CYCLE) begin
            cycle_cnt <= d_mem_data;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_cnt <= '0;
        end else if (mmio_wr && mmio_reg == REG_STORE) begin
            store_cnt <= d_mem_data;
        end else if (ram_wr) begin
            store_cnt <= store_cnt + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio <= '0;
        end else if (mmio_wr && mmio_reg == REG_GPIO) begin
            gpio <= d_mem_data;
        end
    end

    assign gpio_out = gpio;

    always_comb begin
        read_data = '0;
        if (!is_mmio) begin
            read_data = ram[word];
        end else begin
            unique case (mmio_reg)
                REG_CYCLE: read_data = cycle_cnt;
                REG_STORE: read_data = store_cnt;
                REG_GPIO:  read_data = gpio;
                REG_ID:    read_data = ID_VALUE;
                default:   read_data = '0;
            endcase
        end
    end

    assign d_mem_data = d_mem_we ? 'z : read_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset, RAM, bus ownership, counters,
// GPIO/ID and asynchronous mid-operation reset.
module tb_dmem_responder;

    localparam logic [63:0] ID_VALUE = 64'h0000_0000_D0E5_0001;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [5:0]  addr;
    logic [63:0] drv;
    wire  [63:0] d_mem_data;
    logic [63:0] gpio_out;

    int n_checks;
    int n_fail;

    assign d_mem_data = we ? drv : 'z;

    dmem_responder #(.d_addr_63(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_mem_we   (we),
        .d_mem_addr (addr),
        .d_mem_data (d_mem_data),
        .gpio_out   (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write cycle: bench owns the bus; the value seen must be exactly ours.
    task automatic wr(input logic [5:0] a, input logic [63:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = a;
        drv  = d;
        #1 check("bus_during_write", d_mem_data, d);
        @(posedge clk);
    endtask

    task automatic rd(input logic [5:0] a, input logic [63:0] exp, input string tag);
        @(negedge clk);
        we   = 1'b0;
        addr = a;
        #1 check(tag, d_mem_data, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 6'h00;
        drv   = 64'h1;

        #12;
        check("reset_read_ram0", d_mem_data, 64'h0);
        check("reset_gpio_out", gpio_out, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        rd(6'h20, 64'd5, "cycle_after_5_edges");

        wr(6'h08, 64'hDEAD_BEEF_0123_4567);
        rd(6'h08, 64'hDEAD_BEEF_0123_4567, "ram_readback");
        rd(6'h0F, 64'hDEAD_BEEF_0123_4567, "ram_unaligned_0f");
        rd(6'h0B, 64'hDEAD_BEEF_0123_4567, "ram_unaligned_0b");
        rd(6'h10, 64'h0, "ram_other_word");
        rd(6'h28, 64'd1, "store_cnt_one");

        wr(6'h20, 64'hFFFF_FFFF_FFFF_FFFE);
        rd(6'h20, 64'hFFFF_FFFF_FFFF_FFFE, "cycle_loaded");
        rd(6'h20, 64'hFFFF_FFFF_FFFF_FFFF, "cycle_max");
        rd(6'h20, 64'h0, "cycle_wrap");

        wr(6'h28, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(6'h28, 64'hFFFF_FFFF_FFFF_FFFF, "store_cnt_loaded");
        wr(6'h00, 64'h1234);
        rd(6'h28, 64'h0, "store_cnt_wrap");
        rd(6'h00, 64'h1234, "ram0_readback");

        wr(6'h30, 64'hA5);
        rd(6'h30, 64'hA5, "gpio_readback");
        check("gpio_out_after_write", gpio_out, 64'hA5);
        wr(6'h38, 64'h5555);
        rd(6'h38, ID_VALUE, "id_after_write");
        rd(6'h28, 64'h0, "mmio_writes_not_counted");

        wr(6'h10, 64'h1111);
        wr(6'h18, 64'h2222);
        rd(6'h28, 64'd2, "store_cnt_two");
        rd(6'h18, 64'h2222, "ram3_readback");

        // Asynchronous reset pulse placed mid-low-phase, away from any edge.
        @(negedge clk);
        we   = 1'b0;
        addr = 6'h30;
        #2 rst_n = 1'b0;
        #1 check("gpio_out_async_clear", gpio_out, 64'h0);
        check("gpio_read_in_reset", d_mem_data, 64'h0);
        addr = 6'h20;
        #1 check("cycle_in_reset", d_mem_data, 64'h0);
        addr = 6'h28;
        #1 check("store_in_reset", d_mem_data, 64'h0);
        addr = 6'h38;
        #1 check("id_in_reset", d_mem_data, ID_VALUE);

        @(negedge clk);
        rst_n = 1'b1;
        rd(6'h20, 64'd1, "cycle_first_edge");
        for (int unsigned i = 0; i < 4; i++) begin
            logic [5:0] a;
            a = 6'(i * 8);
            rd(a, 64'h0, "ram_cleared");
        end
        rd(6'h28, 64'h0, "store_cleared");
        rd(6'h30, 64'h0, "gpio_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
